// File: rtl/serializador_tx_if.sv
// Parallel-lane side of the 32f serial transmitter: lane bytes, valids, acks
// and the serial stream.
interface serializador_tx_if #(
    parameter int NUM_LANES = 4
);
    logic [NUM_LANES-1:0][7:0] in_lane;
    logic [NUM_LANES-1:0]      valid_in;
    logic [NUM_LANES-1:0]      ack;
    logic                      salida_tx;
    logic                      sync_done;

    modport master (output in_lane, valid_in, input ack, salida_tx, sync_done);
    modport slave  (input in_lane, valid_in, output ack, salida_tx, sync_done);
endinterface

// File: rtl/serializador_tx.sv
// 32f serial transmitter: comma preamble after reset, then round-robin byte
// slots over four lanes, MSB first, one bit per clk_32f.
module serializador_tx #(
    parameter int         SYNC_WORDS = 4,
    parameter logic [7:0] IDLE_WORD  = 8'hBC
) (
    input  logic               clk_32f,
    input  logic               reset_L,
    serializador_tx_if.slave   bus
);
    localparam int SYNC_W = (SYNC_WORDS < 2) ? 1 : $clog2(SYNC_WORDS + 1);

    typedef enum logic {SYNC, DATA} state_t;

    state_t            state;
    logic [2:0]        bit_cnt;
    logic [1:0]        lane_cnt;
    logic [SYNC_W-1:0] sync_cnt;
    logic [7:0]        shift;
    logic [7:0]        byte_sel;
    logic [3:0]        ack_q;
    logic              salida_q;
    logic              sync_done_q;

    // Byte offered at the next load edge; only sampled when bit_cnt == 0.
    always_comb begin
        byte_sel = IDLE_WORD;
        if (state == DATA && bus.valid_in[lane_cnt])
            byte_sel = bus.in_lane[lane_cnt];
    end

    always_ff @(posedge clk_32f or negedge reset_L) begin
        if (!reset_L) begin
            state       <= SYNC;
            bit_cnt     <= 3'd0;
            lane_cnt    <= 2'd0;
            sync_cnt    <= '0;
            shift       <= 8'd0;
            ack_q       <= 4'd0;
            salida_q    <= 1'b0;
            sync_done_q <= 1'b0;
        end else begin
            bit_cnt <= bit_cnt + 3'd1;
            ack_q   <= 4'd0;
            if (bit_cnt == 3'd0) begin
                salida_q <= byte_sel[7];
                shift    <= {byte_sel[6:0], 1'b0};
                case (state)
                    SYNC: begin
                        sync_cnt <= sync_cnt + SYNC_W'(1);
                        // The comma issued here is the last one of the preamble.
                        if (sync_cnt == SYNC_W'(SYNC_WORDS - 1)) begin
                            state       <= DATA;
                            sync_done_q <= 1'b1;
                        end
                    end
                    DATA: begin
                        if (bus.valid_in[lane_cnt])
                            ack_q[lane_cnt] <= 1'b1;
                        lane_cnt <= lane_cnt + 2'd1;
                    end
                    default: state <= SYNC;
                endcase
            end else begin
                salida_q <= shift[7];
                shift    <= {shift[6:0], 1'b0};
            end
        end
    end

    assign bus.ack       = ack_q;
    assign bus.salida_tx = salida_q;
    assign bus.sync_done = sync_done_q;
endmodule

// File: tb/tb_serializador_tx.sv
// Directed bench for serializador_tx: comma preamble, lane slot vectors,
// async reset mid-byte and in-flight input changes.
module tb_serializador_tx;
    logic clk_32f = 1'b0;
    logic reset_L;
    int   checks = 0;
    int   errors = 0;

    serializador_tx_if bus ();

    serializador_tx #(.SYNC_WORDS(4), .IDLE_WORD(8'hBC)) dut (
        .clk_32f (clk_32f),
        .reset_L (reset_L),
        .bus     (bus.slave)
    );

    always #5 clk_32f = ~clk_32f;

    typedef struct {
        logic [3:0][7:0] din;
        logic [3:0]      vld;
        logic [3:0][7:0] exp_b;
        string           name;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One 8-cycle slot: collect the serial byte and check the ack pattern.
    task automatic run_slot(input logic [7:0] eb, input logic ev, input int lane,
                            input string nm, output logic sd_first);
        logic [7:0] got;
        logic [3:0] ea;
        logic       ack_ok;
        got = 8'd0; ack_ok = 1'b1; sd_first = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk_32f); #1;
            got = {got[6:0], bus.salida_tx};
            ea  = (k == 0 && ev) ? (4'b0001 << lane) : 4'b0000;
            if (bus.ack !== ea) ack_ok = 1'b0;
            if (k == 0) sd_first = bus.sync_done;
        end
        chk($sformatf("%s lane%0d byte", nm, lane), {24'd0, got}, {24'd0, eb});
        chk($sformatf("%s lane%0d ack", nm, lane), {31'd0, ack_ok}, 32'd1);
    endtask

    task automatic sync_frame(input string nm);
        logic sd;
        for (int l = 0; l < 4; l++) begin
            run_slot(8'hBC, 1'b0, l, nm, sd);
            if (l == 0) chk({nm, " sync_done slot0"}, {31'd0, sd}, 32'd0);
            if (l == 2) chk({nm, " sync_done after 24"}, {31'd0, bus.sync_done}, 32'd0);
            if (l == 3) chk({nm, " sync_done at 25"}, {31'd0, sd}, 32'd1);
        end
        chk({nm, " sync_done end"}, {31'd0, bus.sync_done}, 32'd1);
    endtask

    task automatic data_frame(input vec_t v);
        logic sd;
        bus.in_lane  = v.din;
        bus.valid_in = v.vld;
        for (int l = 0; l < 4; l++)
            run_slot(v.exp_b[l], v.vld[l], l, v.name, sd);
    endtask

    initial begin
        logic  sd;
        vec_t  v5;

        vecs[0] = '{din: {8'h11, 8'h22, 8'h33, 8'h44}, vld: 4'b0000,
                    exp_b: {8'hBC, 8'hBC, 8'hBC, 8'hBC}, name: "idle"};
        vecs[1] = '{din: {8'hAB, 8'hBA, 8'hBD, 8'hBD}, vld: 4'b1111,
                    exp_b: {8'hAB, 8'hBA, 8'hBD, 8'hBD}, name: "all_valid"};
        vecs[2] = '{din: {8'hAB, 8'hBA, 8'hBD, 8'hBD}, vld: 4'b1101,
                    exp_b: {8'hAB, 8'hBA, 8'hBC, 8'hBD}, name: "lane1_empty"};
        vecs[3] = '{din: {8'h78, 8'h56, 8'h34, 8'h12}, vld: 4'b1010,
                    exp_b: {8'h78, 8'hBC, 8'h34, 8'hBC}, name: "odd_lanes"};
        vecs[4] = '{din: {8'h7E, 8'h81, 8'h00, 8'hFF}, vld: 4'b1111,
                    exp_b: {8'h7E, 8'h81, 8'h00, 8'hFF}, name: "edge_bytes"};

        reset_L      = 1'b0;
        bus.in_lane  = '0;
        bus.valid_in = 4'b0000;
        #2;
        chk("reset salida_tx", {31'd0, bus.salida_tx}, 32'd0);
        chk("reset ack", {28'd0, bus.ack}, 32'd0);
        chk("reset sync_done", {31'd0, bus.sync_done}, 32'd0);
        repeat (2) @(posedge clk_32f);
        #1 reset_L = 1'b1;

        sync_frame("preamble");
        foreach (vecs[i]) data_frame(vecs[i]);

        // Async reset just after lane 1's load edge, with its ack high.
        bus.in_lane  = vecs[1].din;
        bus.valid_in = 4'b1111;
        run_slot(8'hBD, 1'b1, 0, "pre_reset", sd);
        @(posedge clk_32f); #1;
        chk("pre_reset salida_tx", {31'd0, bus.salida_tx}, 32'd1);
        chk("pre_reset ack1", {28'd0, bus.ack}, 32'h2);
        #2 reset_L = 1'b0;
        #1;
        chk("async reset salida_tx", {31'd0, bus.salida_tx}, 32'd0);
        chk("async reset ack", {28'd0, bus.ack}, 32'd0);
        chk("async reset sync_done", {31'd0, bus.sync_done}, 32'd0);
        repeat (2) @(posedge clk_32f);
        #1 reset_L = 1'b1;
        sync_frame("re_preamble");
        data_frame(vecs[1]);

        // Inputs changing after their load edge must not disturb the byte in flight.
        v5 = '{din: {8'hAB, 8'h5A, 8'hBD, 8'h3C}, vld: 4'b1111,
               exp_b: {8'hAB, 8'h5A, 8'hBD, 8'h3C}, name: "in_flight"};
        fork
            begin
                repeat (3) @(posedge clk_32f);
                #2 bus.in_lane[0] = 8'hC3;
                repeat (16) @(posedge clk_32f);
                #2 bus.in_lane[2] = 8'h11;
                bus.valid_in[2] = 1'b0;
            end
        join_none
        data_frame(v5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
